qdec: RTL and testbench

Quadrature decoder for incremental encoder inputs. It synchronizes and glitch-filters the asynchronous A/B channels, then decodes Gray-code transitions into single-cycle `step` strobes with a `dir` level. It also keeps a wrapping position count. `step`/`dir` plug directly into the `ena`/`dir` inputs of the codebase's fixed-step binary counters, so the block is the producing end of that count interface.

---
 rtl/qdec_pkg.sv | 52 +++++
 rtl/qdec_filt.sv | 67 ++++++
 rtl/qdec.sv | 101 ++++++++++
 tb/tb_qdec.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/qdec_pkg.sv
// Shared types and the Gray-code transition decoder for the quadrature decoder.
package qdec_pkg;

    typedef enum logic [1:0] {
        MODE_X1,
        MODE_X2,
        MODE_X4
    } qdec_mode_t;

    typedef enum logic {
        ST_INIT,
        ST_TRACK
    } qdec_state_t;

    typedef struct packed {
        logic count;
        logic dir;
        logic illegal;
    } qdec_dec_t;

    // Position of an {A,B} pair along the forward sequence 00->10->11->01.
    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        return {ab[0], ab[1] ^ ab[0]};
    endfunction

    // Classify a prev->cur {A,B} move: counted step, its direction, or illegal jump.
    function automatic qdec_dec_t qdec_decode(input logic [1:0]  prev_ab,
                                              input logic [1:0]  cur_ab,
                                              input qdec_mode_t  mode);
        qdec_dec_t  r;
        logic [1:0] delta;
        logic       fwd;
        logic       rev;
        logic       a_edge;
        logic       x1_edge;
        delta   = gray_pos(cur_ab) - gray_pos(prev_ab);
        fwd     = (delta == 2'd1);
        rev     = (delta == 2'd3);
        a_edge  = prev_ab[1] ^ cur_ab[1];
        // X1 only counts the 00<->10 edge pair
        x1_edge = a_edge & ~prev_ab[0] & ~cur_ab[0];
        r.illegal = (delta == 2'd2);
        r.dir     = fwd;
        case (mode)
            MODE_X1: r.count = (fwd | rev) & x1_edge;
            MODE_X2: r.count = (fwd | rev) & a_edge;
            default: r.count = fwd | rev;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/qdec_filt.sv
// Per-channel 2-flop synchronizer followed by a consecutive-cycle stability filter.
module qdec_filt
    import qdec_pkg::*;
#(
    parameter int unsigned FILTER = 4
) (
    input  logic clk_i,
    input  logic aclr_i,
    input  logic d_i,
    output logic filt_o,
    output logic stable_seen_o
);

    localparam int unsigned CW = (FILTER > 1) ? $clog2(FILTER) : 1;

    logic [1:0]    sync_q;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] stab_q, stab_d;
    logic          seen_q, seen_d;

    // Filter accept counter and sticky "has been stable for FILTER cycles" flag
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        stab_d = stab_q;
        seen_d = seen_q;
        if (sync_q[1] == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(FILTER - 1)) begin
            filt_d = sync_q[1];
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        if (sync_q[1] != filt_q) begin
            stab_d = '0;
        end else if (!seen_q) begin
            if (stab_q == CW'(FILTER - 1)) begin
                seen_d = 1'b1;
            end else begin
                stab_d = stab_q + CW'(1);
            end
        end
    end

    // Synchronizer and filter state registers
    always_ff @(posedge clk_i or posedge aclr_i) begin
        if (aclr_i) begin
            sync_q <= '0;
            filt_q <= 1'b0;
            cnt_q  <= '0;
            stab_q <= '0;
            seen_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], d_i};
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
            stab_q <= stab_d;
            seen_q <= seen_d;
        end
    end

    assign filt_o        = filt_q;
    assign stable_seen_o = seen_q;

endmodule

// File: rtl/qdec.sv
// Quadrature decoder: filtered A/B channels -> step/dir strobes, error strobe, position.
module qdec
    import qdec_pkg::*;
#(
    parameter int unsigned FILTER    = 4,
    parameter              MODE      = "X4",
    parameter int unsigned POS_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 aclr,
    input  logic                 ena,
    input  logic                 a_in,
    input  logic                 b_in,
    input  logic                 clr_pos,
    output logic                 step,
    output logic                 dir,
    output logic                 err,
    output logic [POS_WIDTH-1:0] pos
);

    localparam qdec_mode_t MODE_E = (MODE == "X1") ? MODE_X1 :
                                    (MODE == "X2") ? MODE_X2 : MODE_X4;

    logic                 a_filt, b_filt;
    logic                 a_seen, b_seen;
    logic [1:0]           cur_ab;
    qdec_dec_t            dec_c;
    qdec_state_t          state_q;
    logic [1:0]           prev_q;
    logic                 step_q, dir_q, err_q;
    logic [POS_WIDTH-1:0] pos_q;

    qdec_filt #(.FILTER(FILTER)) u_filt_a (
        .clk_i         (clk),
        .aclr_i        (aclr),
        .d_i           (a_in),
        .filt_o        (a_filt),
        .stable_seen_o (a_seen)
    );

    qdec_filt #(.FILTER(FILTER)) u_filt_b (
        .clk_i         (clk),
        .aclr_i        (aclr),
        .d_i           (b_in),
        .filt_o        (b_filt),
        .stable_seen_o (b_seen)
    );

    assign cur_ab = {a_filt, b_filt};
    assign dec_c  = qdec_decode(prev_q, cur_ab, MODE_E);

    // INIT/TRACK sequencer with registered step/dir/err; prev AB always follows filtered AB
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q <= ST_INIT;
            prev_q  <= 2'b00;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
            dir_q   <= 1'b1;
        end else begin
            step_q <= 1'b0;
            err_q  <= 1'b0;
            prev_q <= cur_ab;
            case (state_q)
                ST_INIT: begin
                    if (a_seen && b_seen) begin
                        state_q <= ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (ena) begin
                        if (dec_c.illegal) begin
                            err_q <= 1'b1;
                        end else if (dec_c.count) begin
                            step_q <= 1'b1;
                            dir_q  <= dec_c.dir;
                        end
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    // Wrapping position counter; clear has priority over a pending step
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            pos_q <= '0;
        end else if (clr_pos) begin
            pos_q <= '0;
        end else if (ena && step_q) begin
            pos_q <= dir_q ? pos_q + POS_WIDTH'(1) : pos_q - POS_WIDTH'(1);
        end
    end

    assign step = step_q;
    assign dir  = dir_q;
    assign err  = err_q;
    assign pos  = pos_q;

endmodule

// File: tb/tb_qdec.sv
// Bench for qdec: X4/X2/X1 instances side by side against a phase-level reference model.
module tb_qdec;

    localparam int unsigned FILT = 4;
    localparam int          LAT  = FILT + 3;

    logic        clk;
    logic        aclr;
    logic        ena;
    logic        a_in;
    logic        b_in;
    logic        clr_pos;
    logic [2:0]  step_w;
    logic [2:0]  dir_w;
    logic [2:0]  err_w;
    logic [15:0] pos_w [3];

    int          n_chk;
    int          n_fail;

    // reference model state: index 0 = X4, 1 = X2, 2 = X1
    logic [1:0]  cur_ab;
    logic [15:0] exp_pos [3];
    logic        exp_dir [3];

    qdec #(.FILTER(FILT), .MODE("X4"), .POS_WIDTH(16)) u_x4 (
        .clk(clk), .aclr(aclr), .ena(ena), .a_in(a_in), .b_in(b_in), .clr_pos(clr_pos),
        .step(step_w[0]), .dir(dir_w[0]), .err(err_w[0]), .pos(pos_w[0])
    );
    qdec #(.FILTER(FILT), .MODE("X2"), .POS_WIDTH(16)) u_x2 (
        .clk(clk), .aclr(aclr), .ena(ena), .a_in(a_in), .b_in(b_in), .clr_pos(clr_pos),
        .step(step_w[1]), .dir(dir_w[1]), .err(err_w[1]), .pos(pos_w[1])
    );
    qdec #(.FILTER(FILT), .MODE("X1"), .POS_WIDTH(16)) u_x1 (
        .clk(clk), .aclr(aclr), .ena(ena), .a_in(a_in), .b_in(b_in), .clr_pos(clr_pos),
        .step(step_w[2]), .dir(dir_w[2]), .err(err_w[2]), .pos(pos_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // position of an {A,B} value along the forward cycle 00,10,11,01
    function automatic int seq_pos(input logic [1:0] ab);
        logic [1:0] fwd_seq [4];
        int p;
        fwd_seq = '{2'b00, 2'b10, 2'b11, 2'b01};
        p = 0;
        for (int i = 0; i < 4; i++) if (fwd_seq[i] == ab) p = i;
        return p;
    endfunction

    // whether mode m counts a legal move old->nw
    function automatic bit mode_counts(input int m, input logic [1:0] old, input logic [1:0] nw);
        int d;
        bit legal;
        d = (seq_pos(nw) - seq_pos(old) + 4) % 4;
        legal = (d == 1) || (d == 3);
        if (m == 0) return legal;
        if (m == 1) return legal && (old[1] != nw[1]);
        return legal && ((old == 2'b00 && nw == 2'b10) || (old == 2'b10 && nw == 2'b00));
    endfunction

    task automatic check_all(input int k, input bit [2:0] exp_step, input bit exp_err);
        for (int m = 0; m < 3; m++) begin
            check_eq($sformatf("step_m%0d_k%0d", m, k), 32'(step_w[m]), 32'(exp_step[m]));
            check_eq($sformatf("err_m%0d_k%0d", m, k), 32'(err_w[m]), 32'(exp_err));
            check_eq($sformatf("dir_m%0d_k%0d", m, k), 32'(dir_w[m]), 32'(exp_dir[m]));
            check_eq($sformatf("pos_m%0d_k%0d", m, k), 32'(pos_w[m]), 32'(exp_pos[m]));
        end
    endtask

    task automatic do_reset(input logic [1:0] ab, input int settle);
        a_in = ab[1];
        b_in = ab[0];
        clr_pos = 1'b0;
        aclr = 1'b1;
        tick();
        tick();
        for (int m = 0; m < 3; m++) begin
            exp_pos[m] = '0;
            exp_dir[m] = 1'b1;
        end
        check_all(-1, 3'b000, 1'b0);
        aclr = 1'b0;
        cur_ab = ab;
        for (int k = 0; k < settle; k++) begin
            tick();
            check_all(k, 3'b000, 1'b0);
        end
    endtask

    // move inputs to nab and hold for 'hold' cycles, checking every cycle
    task automatic phase(input logic [1:0] nab, input int hold, input bit do_clr);
        int d;
        bit fwd;
        bit ill;
        bit [2:0] cnt;
        d   = (seq_pos(nab) - seq_pos(cur_ab) + 4) % 4;
        fwd = (d == 1);
        ill = (d == 2);
        for (int m = 0; m < 3; m++) cnt[m] = mode_counts(m, cur_ab, nab);
        a_in   = nab[1];
        b_in   = nab[0];
        cur_ab = nab;
        for (int k = 1; k <= hold; k++) begin
            tick();
            for (int m = 0; m < 3; m++) begin
                if (k == LAT && ena && cnt[m]) exp_dir[m] = fwd;
                if (k == LAT + 1) begin
                    if (do_clr) exp_pos[m] = '0;
                    else if (ena && cnt[m]) exp_pos[m] = fwd ? exp_pos[m] + 16'd1 : exp_pos[m] - 16'd1;
                end
            end
            check_all(k, (k == LAT && ena) ? cnt : 3'b000, (k == LAT) && ena && ill);
            clr_pos = do_clr && (k == LAT);
        end
        clr_pos = 1'b0;
    endtask

    // pulse A high for len cycles starting from AB=00
    task automatic glitch(input int len);
        bit acc;
        acc  = (len >= int'(FILT));
        a_in = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            tick();
            for (int m = 0; m < 3; m++) begin
                if (acc && k == LAT)           exp_dir[m] = 1'b1;
                if (acc && k == LAT + 1)       exp_pos[m] = exp_pos[m] + 16'd1;
                if (acc && k == LAT + len)     exp_dir[m] = 1'b0;
                if (acc && k == LAT + len + 1) exp_pos[m] = exp_pos[m] - 16'd1;
            end
            check_all(k, (acc && (k == LAT || k == LAT + len)) ? 3'b111 : 3'b000, 1'b0);
            if (k == len) a_in = 1'b0;
        end
    endtask

    initial begin
        logic [1:0] fwd_seq [4];
        logic [1:0] nab;
        fwd_seq = '{2'b00, 2'b10, 2'b11, 2'b01};
        n_chk   = 0;
        n_fail  = 0;
        ena     = 1'b1;
        a_in    = 1'b0;
        b_in    = 1'b0;
        clr_pos = 1'b0;
        aclr    = 1'b1;
        cur_ab  = 2'b00;
        #1;

        // reset values and INIT settling from 00
        do_reset(2'b00, 20);

        // eight forward steps: X4 -> 8, X2 -> 4, X1 -> 2
        for (int i = 1; i <= 8; i++) phase(fwd_seq[i % 4], 20, 1'b0);
        check_eq("pos_fwd8_x4", 32'(pos_w[0]), 32'd8);

        // three reverse steps from zero
        do_reset(2'b00, 20);
        for (int i = 3; i >= 1; i--) phase(fwd_seq[i], 20, 1'b0);
        check_eq("pos_rev3_x4", 32'(pos_w[0]), 32'hFFFD);

        // short glitch rejected, glitch of FILTER cycles counts there and back
        do_reset(2'b00, 20);
        glitch(3);
        glitch(4);

        // both channels together: illegal both ways
        phase(2'b11, 20, 1'b0);
        phase(2'b00, 20, 1'b0);

        // inputs held at 11 through reset, then a legal forward move
        do_reset(2'b11, 30);
        phase(2'b01, 20, 1'b0);

        // clear coincident with a step
        phase(2'b00, 20, 1'b1);
        phase(2'b10, 20, 1'b0);

        // disabled across five steps, then re-enabled
        ena = 1'b0;
        for (int i = 0; i < 5; i++) phase(fwd_seq[(seq_pos(cur_ab) + 1) % 4], 12, 1'b0);
        ena = 1'b1;
        phase(fwd_seq[(seq_pos(cur_ab) + 1) % 4], 12, 1'b0);

        // random walk including illegal moves, holds, clears and enable toggles
        for (int i = 0; i < 80; i++) begin
            nab = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) ena = ~ena;
            phase(nab, int'($urandom_range(9, 16)), $urandom_range(0, 9) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
